regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 137 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Register file with two combinational read ports, one write
//                port and a per-register busy scoreboard. The scoreboard
//                tracks destinations that have been issued but not yet
//                written back, and keeps a running count of them.
//
//  Ports
//    clk          in   1            rising-edge clock
//    rst          in   1            asynchronous active-high reset
//    rs, rt       in   ADDR_WIDTH   read addresses
//    readData1/2  out  DATA_WIDTH   data at rs / rt
//    rs_busy      out  1            rs has a pending write
//    rt_busy      out  1            rt has a pending write
//    regWrite     in   1            writeback enable
//    rd           in   ADDR_WIDTH   writeback address
//    writeData    in   DATA_WIDTH   writeback data
//    issue_valid  in   1            mark issue_rd as pending
//    issue_rd     in   ADDR_WIDTH   destination being issued
//    busy_count   out  ADDR_WIDTH+1 number of busy registers
//
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic                  rs_busy,
    output logic                  rt_busy,
    input  logic                  regWrite,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam int c_NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [c_NUM_REGS];
    logic [c_NUM_REGS-1:0] r_busy;
    logic [ADDR_WIDTH:0]   r_busy_count;

    logic w_wr_en;      // write that actually lands in the array
    logic w_set;        // issue that actually sets a busy bit
    logic w_inc;
    logic w_dec;
    logic w_rd_hit_rs;
    logic w_rd_hit_rt;
    logic w_rs_zero;
    logic w_rt_zero;

    // Register 0 is hardwired only when ZERO_REG is set.
    assign w_rs_zero = (ZERO_REG != 0) && (rs == '0);
    assign w_rt_zero = (ZERO_REG != 0) && (rt == '0);

    assign w_wr_en = regWrite && !((ZERO_REG != 0) && (rd == '0));
    assign w_set   = issue_valid && !((ZERO_REG != 0) && (issue_rd == '0));

    // Count moves up only when a clear bit gets set, down only when a set bit
    // is cleared and not re-issued in the same cycle.
    assign w_inc = w_set && !r_busy[issue_rd];
    assign w_dec = regWrite && r_busy[rd] && !(w_set && (issue_rd == rd));

    // Forwarding is suppressed during reset so nothing leaks past the clear.
    assign w_rd_hit_rs = (BYPASS != 0) && !rst && regWrite && (rd == rs);
    assign w_rd_hit_rt = (BYPASS != 0) && !rst && regWrite && (rd == rt);

    // ---------------------------------------------------------------- storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rd] <= writeData;
        end
    end

    // -------------------------------------------------------------- scoreboard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            // Clear first, then set, so a same-cycle issue wins.
            for (int i = 0; i < c_NUM_REGS; i++) begin
                if (w_set && (issue_rd == i[ADDR_WIDTH-1:0])) begin
                    r_busy[i] <= 1'b1;
                end else if (regWrite && (rd == i[ADDR_WIDTH-1:0])) begin
                    r_busy[i] <= 1'b0;
                end
            end
            r_busy_count <= r_busy_count
                          + {{ADDR_WIDTH{1'b0}}, w_inc}
                          - {{ADDR_WIDTH{1'b0}}, w_dec};
        end
    end

    // ------------------------------------------------------------ read ports
    always_comb begin
        readData1 = r_regs[rs];
        rs_busy   = r_busy[rs];
        if (w_rs_zero) begin
            readData1 = '0;
            rs_busy   = 1'b0;
        end else if (w_rd_hit_rs) begin
            readData1 = writeData;
            rs_busy   = 1'b0;
        end
    end

    always_comb begin
        readData2 = r_regs[rt];
        rt_busy   = r_busy[rt];
        if (w_rt_zero) begin
            readData2 = '0;
            rt_busy   = 1'b0;
        end else if (w_rd_hit_rt) begin
            readData2 = writeData;
            rt_busy   = 1'b0;
        end
    end

    assign busy_count = r_busy_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Directed self-checking bench for regfile_scoreboard with
//                default parameters (32-bit data, 32 registers, r0 hardwired,
//                bypass enabled), followed by a short random issue/write run
//                checked against a bench-side busy/data model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [4:0]  rs, rt, rd, issue_rd;
    logic [31:0] readData1, readData2, writeData;
    logic        rs_busy, rt_busy, regWrite, issue_valid;
    logic [5:0]  busy_count;

    int n_cmp;
    int n_err;

    logic        m_busy [32];
    logic [31:0] m_regs [32];

    regfile_scoreboard #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .ZERO_REG   (1),
        .BYPASS     (1)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rs          (rs),
        .rt          (rt),
        .readData1   (readData1),
        .readData2   (readData2),
        .rs_busy     (rs_busy),
        .rt_busy     (rt_busy),
        .regWrite    (regWrite),
        .rd          (rd),
        .writeData   (writeData),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy_count  (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, landing 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regWrite    = 1'b0;
        issue_valid = 1'b0;
        rd          = '0;
        issue_rd    = '0;
        writeData   = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        rs = '0;
        rt = '0;
        idle();

        // ---------------- reset state
        #2;
        rs = 5'd5;
        #1;
        chk("reset_count", busy_count, 0);
        chk("reset_rd1", readData1, 0);
        chk("reset_rsbusy", rs_busy, 0);
        tick();
        rst = 1'b0;
        #1;

        // ---------------- write r5, same-cycle bypass then stored value
        regWrite = 1'b1; rd = 5'd5; writeData = 32'hDEADBEEF;
        rs = 5'd5; rt = 5'd5;
        #1;
        chk("r5_bypass_rd1", readData1, 32'hDEADBEEF);
        chk("r5_bypass_rd2", readData2, 32'hDEADBEEF);
        tick();
        idle();
        #1;
        chk("r5_stored", readData1, 32'hDEADBEEF);

        // ---------------- r0 hardwired
        regWrite = 1'b1; rd = 5'd0; writeData = 32'h12345678;
        issue_valid = 1'b1; issue_rd = 5'd0; rs = 5'd0;
        #1;
        chk("r0_samecycle", readData1, 0);
        tick();
        idle();
        #1;
        chk("r0_read", readData1, 0);
        chk("r0_issue_count", busy_count, 0);

        // ---------------- issue r3, r7; writeback r3
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        chk("issue3_count", busy_count, 1);
        issue_rd = 5'd7;
        tick();
        chk("issue7_count", busy_count, 2);
        idle();
        rs = 5'd3; rt = 5'd7;
        #1;
        chk("rs3_busy", rs_busy, 1);
        chk("rt7_busy", rt_busy, 1);
        regWrite = 1'b1; rd = 5'd3; writeData = 32'h33;
        #1;
        chk("wb3_rsbusy_bypass", rs_busy, 0);
        chk("wb3_rtbusy_kept", rt_busy, 1);
        tick();
        idle();
        #1;
        chk("wb3_count", busy_count, 1);
        chk("wb3_rsbusy", rs_busy, 0);
        chk("wb3_data", readData1, 32'h33);

        // same-cycle issue does not show on rs_busy until next cycle
        issue_valid = 1'b1; issue_rd = 5'd10; rs = 5'd10;
        #1;
        chk("issue10_samecycle", rs_busy, 0);
        tick();
        idle();
        #1;
        chk("issue10_next", rs_busy, 1);
        chk("issue10_count", busy_count, 2);

        // ---------------- issue + write same register
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        chk("issue9_count", busy_count, 3);
        issue_valid = 1'b1; issue_rd = 5'd9;
        regWrite = 1'b1; rd = 5'd9; writeData = 32'hA5;
        tick();
        idle();
        rs = 5'd9;
        #1;
        chk("iw9_count", busy_count, 3);
        chk("iw9_busy", rs_busy, 1);
        chk("iw9_data", readData1, 32'hA5);
        // same collision on a non-busy register counts up
        issue_valid = 1'b1; issue_rd = 5'd11;
        regWrite = 1'b1; rd = 5'd11; writeData = 32'h11;
        tick();
        idle();
        #1;
        chk("iw11_count", busy_count, 4);

        // ---------------- writeback to non-busy r4
        regWrite = 1'b1; rd = 5'd4; writeData = 32'h44;
        tick();
        idle();
        #1;
        chk("wb4_nonbusy_count", busy_count, 4);

        // ---------------- fill all nonzero registers, re-issue r1
        for (int i = 1; i < 32; i++) begin
            issue_valid = 1'b1; issue_rd = i[4:0];
            tick();
        end
        idle();
        #1;
        chk("fill_count", busy_count, 31);
        issue_valid = 1'b1; issue_rd = 5'd1;
        tick();
        idle();
        #1;
        chk("reissue1_count", busy_count, 31);

        // ---------------- asynchronous reset mid-cycle
        rs = 5'd9; rt = 5'd5;
        #1;
        rst = 1'b1;
        #1;
        chk("async_count", busy_count, 0);
        chk("async_rd1", readData1, 0);
        chk("async_rd2", readData2, 0);
        chk("async_rsbusy", rs_busy, 0);
        // issue/write held across an edge while in reset are discarded
        issue_valid = 1'b1; issue_rd = 5'd2;
        regWrite = 1'b1; rd = 5'd5; writeData = 32'hBAD;
        tick();
        idle();
        #1;
        chk("rst_issue_discard", busy_count, 0);
        chk("rst_write_discard", readData2, 0);
        rst = 1'b0;
        #1;
        // writeback to formerly busy r7 must not underflow
        regWrite = 1'b1; rd = 5'd7; writeData = 32'h77;
        tick();
        idle();
        #1;
        chk("post_rst_wb_count", busy_count, 0);

        // ---------------- random issue/write against reference model
        for (int i = 0; i < 32; i++) begin
            m_busy[i] = 1'b0;
            m_regs[i] = '0;
        end
        m_regs[7] = 32'h77;
        for (int c = 0; c < 60; c++) begin
            int pc;
            logic [31:0] exp_rd;
            logic        exp_bs;
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 31));
            regWrite    = 1'($urandom_range(0, 1));
            rd          = 5'($urandom_range(0, 31));
            writeData   = $urandom;
            rs          = 5'($urandom_range(0, 31));
            #1;
            if (rs == 5'd0) begin
                exp_rd = '0;
                exp_bs = 1'b0;
            end else if (regWrite && rd == rs) begin
                exp_rd = writeData;
                exp_bs = 1'b0;
            end else begin
                exp_rd = m_regs[rs];
                exp_bs = m_busy[rs];
            end
            chk("rand_rd1", readData1, exp_rd);
            chk("rand_rsbusy", rs_busy, exp_bs);
            if (regWrite) begin
                m_busy[rd] = 1'b0;
                if (rd != 5'd0) m_regs[rd] = writeData;
            end
            if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
            tick();
            pc = 0;
            for (int i = 0; i < 32; i++) pc += int'(m_busy[i]);
            chk("rand_count", busy_count, 64'(pc));
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
